// File: rtl/id_stage.sv
`default_nettype none
// id_stage: decode stage between fetch and execute, with a RAW-hazard stall against execute.
// Optional macro ID_BYPASS_EN replaces the stall with forwarding of es_fwd_value.
module id_stage #(
  parameter int PCW = 8,
  parameter int DW  = 8,
  parameter int RAW = 2,
  parameter int OPW = 4,
  parameter int OHN = 4
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           flush,
  input  logic                           fs_to_ds_valid,
  input  logic [PCW+OPW+2*RAW-1:0]       fs_to_ds_bus,
  output logic                           ds_allowin,
  output logic [RAW-1:0]                 rx,
  output logic [RAW-1:0]                 ry,
  input  logic [DW-1:0]                  rx_value,
  input  logic [DW-1:0]                  ry_value,
  input  logic                           es_dest_valid,
  input  logic [RAW-1:0]                 es_dest,
  input  logic [DW-1:0]                  es_fwd_value,
  input  logic                           es_allowin,
  output logic                           ds_to_es_valid,
  output logic [PCW+2*DW+OHN+RAW:0]      ds_to_es_bus
);

  localparam int FBW = PCW + OPW + 2*RAW;

  logic           ds_valid_q, ds_valid_d;
  logic [FBW-1:0] ds_inst_q, ds_inst_d;
  logic [7:0]     stall_cnt_q, stall_cnt_d;

  logic [PCW-1:0] pc;
  logic [OPW-1:0] op;
  logic [OHN-1:0] op_onehot;
  logic           ill;
  logic [DW-1:0]  rx_val, ry_val;
  logic           hz, ds_ready_go, load, handoff;

  // Fetch bus layout is {pc, op, ry, rx} with rx at the LSBs.
  assign rx = ds_inst_q[RAW-1:0];
  assign ry = ds_inst_q[2*RAW-1:RAW];
  assign op = ds_inst_q[2*RAW +: OPW];
  assign pc = ds_inst_q[2*RAW+OPW +: PCW];

  always_comb begin
    op_onehot = '0;
    for (int k = 1; k <= OHN; k++) begin
      if (op == OPW'(k)) op_onehot[OHN-k] = 1'b1;
    end
  end

  assign ill = ~|op_onehot;

`ifdef ID_BYPASS_EN
  assign hz     = 1'b0;
  assign rx_val = (es_dest_valid && es_dest == rx) ? es_fwd_value : rx_value;
  assign ry_val = (es_dest_valid && es_dest == ry) ? es_fwd_value : ry_value;
`else
  logic unused_fwd;
  assign unused_fwd = ^es_fwd_value;
  assign hz     = ds_valid_q && es_dest_valid && (es_dest == rx || es_dest == ry);
  assign rx_val = rx_value;
  assign ry_val = ry_value;
`endif

  assign ds_ready_go    = !hz;
  assign ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid_q && ds_ready_go && !flush;
  assign load           = fs_to_ds_valid && ds_allowin && !flush;
  assign handoff        = ds_to_es_valid && es_allowin;

  assign ds_to_es_bus = {ill, rx, op_onehot, ry_val, rx_val, pc};

  always_comb begin
    ds_valid_d  = ds_valid_q;
    ds_inst_d   = ds_inst_q;
    stall_cnt_d = stall_cnt_q;
    // Flush wins over both a new load and a hand-off.
    if (flush)        ds_valid_d = 1'b0;
    else if (load)    ds_valid_d = 1'b1;
    else if (handoff) ds_valid_d = 1'b0;
    if (load) ds_inst_d = fs_to_ds_bus;
    if (ds_valid_q && !ds_ready_go && stall_cnt_q != 8'hFF)
      stall_cnt_d = stall_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_valid_q  <= 1'b0;
      ds_inst_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ds_valid_q  <= ds_valid_d;
      ds_inst_q   <= ds_inst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// tb_id_stage: randomized and directed stimulus checked against a cycle-level behavioural model.
module tb_id_stage;
  localparam int PCW = 8, DW = 8, RAW = 2, OPW = 4, OHN = 4;
  localparam int FBW = PCW + OPW + 2*RAW;
  localparam int DBW = PCW + 2*DW + OHN + RAW + 1;

  logic           clk = 1'b0, resetn = 1'b0, flush = 1'b0;
  logic           fs_to_ds_valid = 1'b0, es_dest_valid = 1'b0, es_allowin = 1'b0;
  logic [FBW-1:0] fs_to_ds_bus = '0;
  logic           ds_allowin, ds_to_es_valid;
  logic [RAW-1:0] rx, ry, es_dest = '0;
  logic [DW-1:0]  rx_value, ry_value, es_fwd_value = '0;
  logic [DBW-1:0] ds_to_es_bus;
  logic [DW-1:0]  rf [4];

  assign rx_value = rf[rx];
  assign ry_value = rf[ry];

  always #5 clk = ~clk;

  id_stage #(.PCW(PCW), .DW(DW), .RAW(RAW), .OPW(OPW), .OHN(OHN)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .ds_allowin(ds_allowin), .rx(rx), .ry(ry),
    .rx_value(rx_value), .ry_value(ry_value),
    .es_dest_valid(es_dest_valid), .es_dest(es_dest), .es_fwd_value(es_fwd_value),
    .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int delivered = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Behavioural model: the held instruction as plain fields.
  bit             m_valid = 0;
  int             m_pc = 0, m_op = 0, m_rx = 0, m_ry = 0, m_stall = 0;

  function automatic bit model_hz();
`ifdef ID_BYPASS_EN
    return 1'b0;
`else
    return m_valid && es_dest_valid && (int'(es_dest) == m_rx || int'(es_dest) == m_ry);
`endif
  endfunction

  function automatic logic [DBW-1:0] model_bus();
    logic [OHN-1:0] oh;
    logic [DW-1:0]  xv, yv;
    logic           il;
    oh = '0;
    if (m_op >= 1 && m_op <= OHN) oh[OHN-m_op] = 1'b1;
    il = !(m_op >= 1 && m_op <= OHN);
    xv = rf[m_rx];
    yv = rf[m_ry];
`ifdef ID_BYPASS_EN
    if (es_dest_valid && int'(es_dest) == m_rx) xv = es_fwd_value;
    if (es_dest_valid && int'(es_dest) == m_ry) yv = es_fwd_value;
`endif
    return {il, RAW'(m_rx), oh, yv, xv, PCW'(m_pc)};
  endfunction

  task automatic model_reset();
    m_valid = 0; m_pc = 0; m_op = 0; m_rx = 0; m_ry = 0; m_stall = 0;
  endtask

  task automatic compare(input string tag);
    bit hz, allow, vout;
    hz    = model_hz();
    allow = !m_valid || (!hz && es_allowin);
    vout  = m_valid && !hz && !flush;
    check({tag, "/allowin"}, 64'(ds_allowin), 64'(allow));
    check({tag, "/valid"},   64'(ds_to_es_valid), 64'(vout));
    check({tag, "/rx"},      64'(rx), 64'(m_rx));
    check({tag, "/ry"},      64'(ry), 64'(m_ry));
    check({tag, "/bus"},     64'(ds_to_es_bus), 64'(model_bus()));
    check({tag, "/stall"},   64'(dut.stall_cnt_q), 64'(m_stall));
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic step(input string tag);
    bit hz, allow, vout, load, hand, was_valid;
    #3;
    compare(tag);
    hz        = model_hz();
    allow     = !m_valid || (!hz && es_allowin);
    vout      = m_valid && !hz && !flush;
    load      = fs_to_ds_valid && allow && !flush;
    hand      = vout && es_allowin;
    was_valid = m_valid;
    if (hand) delivered++;
    @(posedge clk);
    if (flush) m_valid = 0;
    else if (load) m_valid = 1;
    else if (hand) m_valid = 0;
    if (load) begin
      m_rx = int'(fs_to_ds_bus[RAW-1:0]);
      m_ry = int'(fs_to_ds_bus[2*RAW-1:RAW]);
      m_op = int'(fs_to_ds_bus[2*RAW +: OPW]);
      m_pc = int'(fs_to_ds_bus[2*RAW+OPW +: PCW]);
    end
    if (was_valid && hz && m_stall < 255) m_stall++;
    #1;
  endtask

  function automatic logic [FBW-1:0] mk(input int pc, input int op, input int ry_f, input int rx_f);
    return {PCW'(pc), OPW'(op), RAW'(ry_f), RAW'(rx_f)};
  endfunction

  initial begin
    int ops[5];
    int d0;
    ops = '{2, 3, 4, 0, 9};
    rf[0] = 8'h00; rf[1] = 8'h11; rf[2] = 8'h22; rf[3] = 8'h33;
    es_fwd_value = 8'hA5;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    compare("reset");
    resetn = 1'b1;

    // First instruction: pc=1A op=1 ry=1 rx=2.
    es_allowin = 1'b1;
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = 16'h1A16;
    step("ld1");
    fs_to_ds_valid = 1'b0;
    step("out1");

    // Remaining opcode decodes including illegal 0 and 9.
    foreach (ops[i]) begin
      fs_to_ds_valid = 1'b1; fs_to_ds_bus = mk(8'h30 + i, ops[i], 3, 1);
      step("opc");
    end
    fs_to_ds_valid = 1'b0;
    step("opc_drain");

    // Back-to-back stream of 8 with no bubble.
    d0 = delivered;
    for (int i = 0; i < 8; i++) begin
      fs_to_ds_valid = 1'b1; fs_to_ds_bus = mk(8'h40 + i, 1 + (i % 4), i % 4, (i + 1) % 4);
      step("stream");
    end
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = mk(8'h50, 2, 0, 1);
    step("stream_last");
    check("stream8", 64'(delivered - d0), 64'd8);

    // Back-pressure for 3 cycles while fetch keeps offering.
    es_allowin = 1'b0; fs_to_ds_bus = mk(8'h60, 3, 1, 3);
    for (int i = 0; i < 3; i++) step("bp");
    es_allowin = 1'b1; fs_to_ds_valid = 1'b0;
    step("bp_rel"); step("bp_drain");

    // RAW hazard on rx=2 held for 2 cycles.
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = mk(8'h70, 1, 1, 2);
    step("hz_ld");
    fs_to_ds_valid = 1'b0; es_dest_valid = 1'b1; es_dest = 2'd2;
    step("hz1"); step("hz2");
`ifdef ID_BYPASS_EN
    check("stall_cnt2", 64'(dut.stall_cnt_q), 64'd0);
`else
    check("stall_cnt2", 64'(dut.stall_cnt_q), 64'd2);
`endif
    es_dest_valid = 1'b0;
    step("hz_rel"); step("hz_drain");

    // Flush together with a fetch offer while an instruction is held.
    es_allowin = 1'b0;
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = mk(8'h80, 2, 2, 3);
    step("fl_ld");
    d0 = delivered;
    flush = 1'b1; fs_to_ds_bus = mk(8'h81, 3, 0, 0);
    es_allowin = 1'b1;
    step("fl");
    flush = 1'b0; fs_to_ds_valid = 1'b0;
    step("fl_after");
    check("flush_nothing_out", 64'(delivered - d0), 64'd0);

    // Asynchronous reset in the middle of a stall.
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = mk(8'h90, 4, 3, 2);
    step("rs_ld");
    fs_to_ds_valid = 1'b0; es_dest_valid = 1'b1; es_dest = 2'd3;
    step("rs_st1"); step("rs_st2");
    resetn = 1'b0;
    #1;
    model_reset();
    compare("rs_async");
    es_dest_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    step("rs_rel");

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      fs_to_ds_valid = ($urandom_range(0, 99) < 70);
      fs_to_ds_bus   = FBW'($urandom);
      es_allowin     = ($urandom_range(0, 99) < 70);
      es_dest_valid  = ($urandom_range(0, 99) < 30);
      es_dest        = RAW'($urandom);
      es_fwd_value   = DW'($urandom);
      flush          = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 9) == 0) rf[$urandom_range(0, 3)] = DW'($urandom);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_stage.md
# id_stage

Parametrised decode stage for the pipelined teaching CPU, sitting between the fetch stage and the execute stage. It registers one instruction from fetch under a valid/allowin handshake and drives the register-file read addresses. It assembles the decode-to-execute bus with PC, operand values and a one-hot opcode, and stalls on read-after-write hazards against the instruction currently in execute. An optional forwarding path replaces the stall.

## Interface
- `PCW`, 8, PC width
- `DW`, 8, register data width
- `RAW`, 2, register address width (2^RAW registers)
- `OPW`, 4, opcode field width
- `OHN`, 4, one-hot opcode width (legal opcodes 1..OHN, OHN ≤ 2^OPW−1)
- `clk` in 1: clock, all state on rising edge
- `resetn` in 1: asynchronous, active-low reset
- `flush` in 1: discard the instruction held in decode
- `fs_to_ds_valid` in 1: fetch bus valid
- `fs_to_ds_bus` in PCW+OPW+2·RAW: {pc, op, ry, rx}, rx at LSBs
- `ds_allowin` out 1: decode can accept this cycle
- `rx`, `ry` out RAW each: register-file read addresses
- `rx_value`, `ry_value` in DW each: register-file read data (combinational)
- `es_dest_valid` in 1: execute holds an instruction that writes a register
- `es_dest` in RAW: destination of that instruction
- `es_fwd_value` in DW: execute result (used only with ID_BYPASS_EN)
- `es_allowin` in 1: execute can accept
- `ds_to_es_valid` out 1: decode bus valid
- `ds_to_es_bus` out PCW+2·DW+OHN+RAW+1: {ill, dest, op_onehot, ry_val, rx_val, pc}, pc at LSBs (31 bits default)

## Operation
- Internal state: `ds_valid` (1 bit), `ds_inst` (fetch bus width), `stall_cnt` (8-bit saturating, debug, visible via hierarchy).
- Load: when `fs_to_ds_valid && ds_allowin && !flush`: `ds_inst ← fs_to_ds_bus`, `ds_valid ← 1`.
- Clear `ds_valid` when `flush` is asserted, or when `ds_to_es_valid && es_allowin` and there is no new load.
- `flush` has priority over load and over hand-off: `ds_valid` is 0 the next cycle.
- `rx`/`ry` come from `ds_inst` fields and are combinational from the register. They are driven even when `ds_valid` = 0.
- Decode:
  - Opcode k in 1..OHN maps to `op_onehot` bit OHN−k set. Defaults: 0001→1000, 0010→0100, 0011→0010, 0100→0001.
  - Any other opcode gives `op_onehot` = 0 and `ill` = 1.
  - `dest` = rx field.
- Hazard: `hz = ds_valid && es_dest_valid && (es_dest == rx || es_dest == ry)`.
- `ds_ready_go = !hz`. `ds_allowin = !ds_valid || (ds_ready_go && es_allowin)`. `ds_to_es_valid = ds_valid && ds_ready_go && !flush`.
- `stall_cnt` increments each cycle that `ds_valid && !ds_ready_go`, and saturates at 255.
- Illegal opcodes are not stalled; they are passed downstream with `ill` = 1.

## Timing
- Reset (`resetn` = 0, asynchronous):
  - `ds_valid` = 0, `ds_inst` = 0, `stall_cnt` = 0.
  - Therefore `ds_to_es_valid` = 0, `ds_allowin` = 1, `rx` = `ry` = 0, `ds_to_es_bus` = {1'b1 ill, 0…} (opcode 0 is illegal).
- Latency:
  - Instruction accepted at edge N → `ds_to_es_valid` is high in cycle N+1 if there is no hazard.
  - Full throughput: one instruction per cycle with `es_allowin` held at 1.
- Back-pressure: if `es_allowin` = 0, `ds_inst` holds and `ds_to_es_bus` stays stable until the accepting edge.
- Simultaneous hand-off and load: the new instruction replaces the old on the same edge; no bubble.
- Hazard stall:
  - Lasts while `es_dest_valid` matches; bus fields stay stable; `ds_allowin` = 0.
  - Released the cycle after execute's register-writing instruction leaves.
- Reset mid-stall drops the held instruction immediately.

## Configuration
- `ID_BYPASS_EN` defined:
  - `hz` is forced to 0.
  - `rx_val` = `es_fwd_value` when `es_dest_valid && es_dest == rx`, else `rx_value`; likewise `ry_val`.
  - `stall_cnt` stays 0.
- Not defined: the stall behaviour above applies and `es_fwd_value` is ignored.

## Test plan
- Reset release, then bus 16'h1A_1_6 (pc=1A, op=1, ry=1, rx=2) with `es_allowin` = 1 → next cycle `ds_to_es_valid` = 1, `rx` = 2, `ry` = 1, onehot = 1000, pc = 1A, `ill` = 0, with register-file values passed through.
- Opcodes 2, 3, 4, 0 and 9 → onehot 0100, 0010, 0001, 0000 (`ill` = 1), 0000 (`ill` = 1).
- Back-to-back stream of 8 instructions with `es_allowin` = 1 → 8 consecutive valid cycles with no bubble; hold `es_allowin` = 0 for 3 cycles → bus stable and `ds_allowin` = 0.
- `es_dest_valid` = 1, `es_dest` = 2 against rx = 2 for 2 cycles → `ds_to_es_valid` = 0 and `stall_cnt` = 2, then release. With `ID_BYPASS_EN`: no stall, and `rx_val` = `es_fwd_value` (8'hA5).
- `flush` asserted together with `fs_to_ds_valid` → `ds_valid` = 0 next cycle and no instruction reaches execute. `resetn` pulsed low during a stall → outputs return to reset values immediately.
